// File: rtl/en_tracker.sv
// Enable-stream tracker: measures en_in spacing, locks onto a nominal period,
// flags out-of-tolerance or missing pulses and emits a mid-period sample strobe.
module en_tracker #(
  parameter int unsigned INTERVAL   = 10,
  parameter int unsigned TOL        = 1,
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned MID_OFFSET = INTERVAL / 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_in,
  input  logic        clear,
  output logic        locked,
  output logic        mid_strobe,
  output logic [31:0] period,
  output logic        err_pulse,
  output logic        miss_pulse,
  output logic [15:0] good_cnt
);

  localparam logic [31:0] Nominal = 32'(INTERVAL + 1);
  localparam logic [31:0] GapHi   = Nominal + 32'(TOL);
  // Lower bound never drops below one cycle, even for very wide tolerances.
  localparam logic [31:0] GapLo   = (TOL >= INTERVAL + 1) ? 32'd1 : Nominal - 32'(TOL);
  localparam logic [31:0] MidGap  = 32'(MID_OFFSET);
  localparam logic [15:0] LockN   = 16'(LOCK_CNT);

  typedef enum logic [1:0] {StIdle, StAcquire, StLocked} state_e;

  state_e      state_q;
  logic [31:0] gap_q;
  logic [15:0] match_q;
  logic        in_tol;
  logic        timeout;

  assign in_tol  = (gap_q >= GapLo) && (gap_q <= GapHi);
  assign timeout = (gap_q == GapHi);

  assign mid_strobe = (state_q == StLocked) && (gap_q == MidGap);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      gap_q      <= '0;
      match_q    <= '0;
      locked     <= 1'b0;
      period     <= '0;
      err_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      good_cnt   <= '0;
    end else begin
      err_pulse  <= 1'b0;
      miss_pulse <= 1'b0;

      if (en_in) begin
        gap_q <= 32'd1;
      end else if (gap_q != '1) begin
        gap_q <= gap_q + 32'd1;
      end

      if (clear) begin
        state_q  <= StIdle;
        match_q  <= '0;
        good_cnt <= '0;
        locked   <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (en_in) begin
              state_q <= StAcquire;
              match_q <= '0;
            end
          end
          StAcquire: begin
            if (en_in) begin
              period <= gap_q;
              if (in_tol) begin
                if (match_q + 16'd1 == LockN) begin
                  state_q <= StLocked;
                  locked  <= 1'b1;
                end
                match_q <= match_q + 16'd1;
              end else begin
                err_pulse <= 1'b1;
                match_q   <= '0;
              end
            end else if (timeout) begin
              miss_pulse <= 1'b1;
              locked     <= 1'b0;
              match_q    <= '0;
              state_q    <= StIdle;
            end
          end
          StLocked: begin
            if (en_in) begin
              period <= gap_q;
              if (in_tol) begin
                if (good_cnt != '1) good_cnt <= good_cnt + 16'd1;
              end else begin
                err_pulse <= 1'b1;
                locked    <= 1'b0;
                match_q   <= '0;
                state_q   <= StAcquire;
              end
            end else if (timeout) begin
              miss_pulse <= 1'b1;
              locked     <= 1'b0;
              match_q    <= '0;
              state_q    <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_en_tracker.sv
// Self-checking bench for en_tracker: directed scenarios plus random pulse
// spacing, compared each cycle against a timestamp-based reference model.
module tb_en_tracker;

  localparam int unsigned INTERVAL = 10;
  localparam int unsigned TOL      = 1;
  localparam int unsigned LOCK_CNT = 4;
  localparam int unsigned MID      = 5;
  localparam int          LO       = INTERVAL + 1 - TOL;
  localparam int          HI       = INTERVAL + 1 + TOL;

  logic        clk   = 1'b0;
  logic        rst   = 1'b0;
  logic        en_in = 1'b0;
  logic        clear = 1'b0;
  logic        locked;
  logic        mid_strobe;
  logic [31:0] period;
  logic        err_pulse;
  logic        miss_pulse;
  logic [15:0] good_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  en_tracker #(
    .INTERVAL  (INTERVAL),
    .TOL       (TOL),
    .LOCK_CNT  (LOCK_CNT),
    .MID_OFFSET(MID)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en_in     (en_in),
    .clear     (clear),
    .locked    (locked),
    .mid_strobe(mid_strobe),
    .period    (period),
    .err_pulse (err_pulse),
    .miss_pulse(miss_pulse),
    .good_cnt  (good_cnt)
  );

  // Reference model: mode 0 idle, 1 acquiring, 2 locked; gap from timestamps.
  int          m_mode   = 0;
  int          m_cnt    = 0;
  int          m_now    = 0;
  int          m_last   = 0;
  int          m_good   = 0;
  logic        m_locked = 1'b0;
  logic        m_err    = 1'b0;
  logic        m_miss   = 1'b0;
  logic [31:0] m_period = '0;

  function automatic logic [51:0] dut_vec();
    return {locked, mid_strobe, err_pulse, miss_pulse, period, good_cnt};
  endfunction

  function automatic logic [51:0] exp_vec();
    int   g;
    logic mid;
    g   = m_now - m_last;
    mid = (m_mode == 2) && (g == MID);
    return {m_locked, mid, m_err, m_miss, m_period, 16'(m_good)};
  endfunction

  task automatic tick(input logic e, input logic c, input logic r);
    int g;
    bit ok;
    g     = m_now - m_last;
    en_in = e;
    clear = c;
    rst   = r;
    m_err  = 1'b0;
    m_miss = 1'b0;
    if (!r) begin
      m_mode = 0; m_cnt = 0; m_locked = 1'b0; m_period = '0; m_good = 0;
      m_last = m_now + 1;
    end else begin
      if (c) begin
        m_mode = 0; m_cnt = 0; m_good = 0; m_locked = 1'b0;
      end else if (m_mode == 0 && e) begin
        m_mode = 1; m_cnt = 0;
      end else if (m_mode != 0 && e) begin
        ok       = (g >= LO) && (g <= HI);
        m_period = 32'(g);
        if (!ok) begin
          m_err = 1'b1; m_cnt = 0;
          if (m_mode == 2) begin m_mode = 1; m_locked = 1'b0; end
        end else if (m_mode == 1) begin
          m_cnt++;
          if (m_cnt == LOCK_CNT) begin m_mode = 2; m_locked = 1'b1; end
        end else if (m_good < 65535) begin
          m_good++;
        end
      end else if (m_mode != 0 && g == HI) begin
        m_miss = 1'b1; m_mode = 0; m_cnt = 0; m_locked = 1'b0;
      end
      if (e) m_last = m_now;
    end
    m_now++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b1, 1'b0);
    n_chk++;
    if (dut_vec() !== 52'd0) begin
      n_fail++; $display("FAIL reset_state: got %h want 0", dut_vec());
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 1'b1);
      n_chk++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL reset_idle: got %h want %h", dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_lock();
    int n_mid = 0;
    tick(1'b0, 1'b0, 1'b0);
    for (int p = 0; p < 8; p++) begin
      for (int c = 1; c <= 11; c++) begin
        tick(c == 11, 1'b0, 1'b1);
        if (mid_strobe === 1'b1) n_mid++;
        n_chk++;
        if (dut_vec() !== exp_vec()) begin
          n_fail++; $display("FAIL lock_cycle: got %h want %h", dut_vec(), exp_vec());
        end
      end
      if (p == 3) begin
        n_chk++;
        if (locked !== 1'b0) begin
          n_fail++; $display("FAIL lock_early: got locked=%b want 0", locked);
        end
      end
      if (p == 4) begin
        n_chk++;
        if (locked !== 1'b1 || period !== 32'd11) begin
          n_fail++; $display("FAIL lock_fifth: got locked=%b period=%0d want 1/11", locked, period);
        end
      end
    end
    n_chk++;
    if (n_mid != 3 || good_cnt !== 16'd3) begin
      n_fail++; $display("FAIL lock_mid_good: got mids=%0d good=%0d want 3/3", n_mid, good_cnt);
    end
  endtask

  task automatic test_bad_locked();
    for (int c = 1; c <= 9; c++) tick(c == 9, 1'b0, 1'b1);
    n_chk++;
    if (err_pulse !== 1'b1 || period !== 32'd9 || locked !== 1'b0) begin
      n_fail++;
      $display("FAIL bad_locked: got err=%b period=%0d locked=%b want 1/9/0",
               err_pulse, period, locked);
    end
    for (int c = 0; c < 14; c++) begin
      tick(1'b0, 1'b0, 1'b1);
      n_chk++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL bad_after: got %h want %h", dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_timeout();
    int gs[$] = '{2, 11, 11, 11, 11, 12};
    tick(1'b0, 1'b0, 1'b0);
    foreach (gs[i]) begin
      for (int c = 1; c <= gs[i]; c++) begin
        tick(c == gs[i], 1'b0, 1'b1);
        n_chk++;
        if (dut_vec() !== exp_vec()) begin
          n_fail++; $display("FAIL timeout_cycle: got %h want %h", dut_vec(), exp_vec());
        end
      end
    end
    n_chk++;
    if (miss_pulse !== 1'b0 || err_pulse !== 1'b0 || period !== 32'd12 || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL gap12_good: got miss=%b err=%b period=%0d locked=%b want 0/0/12/1",
               miss_pulse, err_pulse, period, locked);
    end
    for (int c = 1; c <= 12; c++) tick(1'b0, 1'b0, 1'b1);
    n_chk++;
    if (miss_pulse !== 1'b1 || locked !== 1'b0) begin
      n_fail++; $display("FAIL miss_fire: got miss=%b locked=%b want 1/0", miss_pulse, locked);
    end
    tick(1'b0, 1'b0, 1'b1);
    n_chk++;
    if (miss_pulse !== 1'b0) begin
      n_fail++; $display("FAIL miss_width: got miss=%b want 0", miss_pulse);
    end
    for (int c = 1; c <= 13; c++) tick(c == 13, 1'b0, 1'b1);
    n_chk++;
    if (dut_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL idle_pulse: got %h want %h", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_alternating();
    int ga[$] = '{2, 10, 12, 10, 12};
    int gb[$] = '{2, 10, 12, 9, 10, 12, 10, 12};
    tick(1'b0, 1'b0, 1'b0);
    foreach (ga[i]) for (int c = 1; c <= ga[i]; c++) tick(c == ga[i], 1'b0, 1'b1);
    n_chk++;
    if (locked !== 1'b1) begin
      n_fail++; $display("FAIL alt_lock: got locked=%b want 1", locked);
    end
    tick(1'b0, 1'b0, 1'b0);
    foreach (gb[i]) begin
      for (int c = 1; c <= gb[i]; c++) begin
        tick(c == gb[i], 1'b0, 1'b1);
        n_chk++;
        if (dut_vec() !== exp_vec()) begin
          n_fail++; $display("FAIL alt_cycle: got %h want %h", dut_vec(), exp_vec());
        end
      end
      if (i == 3) begin
        n_chk++;
        if (err_pulse !== 1'b1 || period !== 32'd9) begin
          n_fail++; $display("FAIL alt_gap9: got err=%b period=%0d want 1/9", err_pulse, period);
        end
      end
      if (i == 6) begin
        n_chk++;
        if (locked !== 1'b0) begin
          n_fail++; $display("FAIL alt_restart: got locked=%b want 0", locked);
        end
      end
    end
    n_chk++;
    if (locked !== 1'b1) begin
      n_fail++; $display("FAIL alt_relock: got locked=%b want 1", locked);
    end
  endtask

  task automatic test_reset_midlock();
    int gs[$] = '{2, 11, 11, 11, 11};
    for (int c = 1; c <= 3; c++) tick(1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b1, 1'b0);
    n_chk++;
    if (dut_vec() !== 52'd0) begin
      n_fail++; $display("FAIL rst_midlock: got %h want 0", dut_vec());
    end
    foreach (gs[i]) begin
      for (int c = 1; c <= gs[i]; c++) tick(c == gs[i], 1'b0, 1'b1);
      n_chk++;
      if (locked !== (i == 4)) begin
        n_fail++; $display("FAIL rst_relock: pulse %0d got locked=%b want %b", i + 1, locked, i == 4);
      end
    end
  endtask

  task automatic test_clear();
    int gs[$] = '{11, 11};
    foreach (gs[i]) for (int c = 1; c <= gs[i]; c++) tick(c == gs[i], 1'b0, 1'b1);
    n_chk++;
    if (good_cnt !== 16'd2) begin
      n_fail++; $display("FAIL clear_pre: got good=%0d want 2", good_cnt);
    end
    for (int c = 1; c <= 9; c++) tick(c == 9, c == 9, 1'b1);
    n_chk++;
    if (locked !== 1'b0 || good_cnt !== 16'd0 || period !== 32'd11 || err_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_en: got locked=%b good=%0d period=%0d err=%b want 0/0/11/0",
               locked, good_cnt, period, err_pulse);
    end
    for (int c = 1; c <= 9; c++) begin
      tick(c == 9, 1'b0, 1'b1);
      n_chk++;
      if (dut_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL clear_after: got %h want %h", dut_vec(), exp_vec());
      end
    end
    n_chk++;
    if (period !== 32'd11 || err_pulse !== 1'b0) begin
      n_fail++; $display("FAIL clear_idle: got period=%0d err=%b want 11/0", period, err_pulse);
    end
  endtask

  task automatic test_random();
    int   g;
    logic clr;
    for (int p = 0; p < 80; p++) begin
      g   = $urandom_range(14, 8);
      clr = ($urandom_range(11, 0) == 0);
      for (int c = 1; c <= g; c++) begin
        tick(c == g, clr && (c == g), 1'b1);
        n_chk++;
        if (dut_vec() !== exp_vec() || (err_pulse & miss_pulse) !== 1'b0) begin
          n_fail++; $display("FAIL random: got %h want %h", dut_vec(), exp_vec());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_bad_locked();
    test_timeout();
    test_alternating();
    test_reset_midlock();
    test_clear();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
